// File: rtl/dsram_responder.sv
// ---------------------------------------------------------------------------
// dsram_responder
//
// Data-side SRAM-like slave for the pipeline's data memory port. Requests are
// accepted one per cycle (req & addr_ok), writes are applied byte-strobed at
// the accept edge, and reads sample the word at the accept edge. Every
// accepted request (read or write) produces exactly one data_ok, strictly in
// acceptance order, no earlier than RESP_DELAY cycles after acceptance.
//
// Parameters:
//   MEM_AW     word-address width, memory holds 2^MEM_AW 32-bit words
//   OT_DEPTH   outstanding-request queue depth (power of two, >= 2)
//   RESP_DELAY minimum cycles from accept to data_ok (>= 1)
//
// Ports:
//   clk                clock, all state on rising edge
//   resetn             asynchronous active-low reset
//   data_sram_req      request valid
//   data_sram_wr       1 = write, 0 = read
//   data_sram_size     access size (informational only)
//   data_sram_addr     byte address
//   data_sram_wstrb    byte enables for writes
//   data_sram_wdata    write data
//   data_sram_addr_ok  request accepted this cycle when high with req
//   data_sram_data_ok  response valid for oldest outstanding request
//   data_sram_rdata    read data, 0 when idle or for write responses
//
// Optional feature macro: DSRAM_RAND_DELAY_EN
//   When defined, a 16-bit Fibonacci LFSR randomly stalls addr_ok and adds
//   0-3 extra cycles of response delay per request. Ordering is unchanged.
// ---------------------------------------------------------------------------
module dsram_responder #(
  parameter int MEM_AW     = 10,
  parameter int OT_DEPTH   = 4,
  parameter int RESP_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = $clog2(OT_DEPTH);
  // Counter must hold RESP_DELAY-1 plus up to 3 random extra cycles.
  localparam int CW = $clog2(RESP_DELAY + 4);
  localparam logic [CW-1:0] LOAD_C    = CW'(RESP_DELAY - 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   COUNT_ONE = (PW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [31:0]       r_mem   [0:(1 << MEM_AW) - 1];
  logic              r_qWr   [OT_DEPTH];
  logic [31:0]       r_qData [OT_DEPTH];
  logic [CW-1:0]     r_qCnt  [OT_DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW:0]       r_count;
  logic              r_run;

  logic [MEM_AW-1:0] w_idx;
  logic              w_accept;
  logic              w_pop;
  logic              w_stall;
  logic [CW-1:0]     w_load;
  logic              w_unused;

  assign w_idx = data_sram_addr[MEM_AW+1:2];

  // Size, byte-offset and upper address bits do not affect behaviour.
  assign w_unused = &{1'b0, data_sram_size, data_sram_addr[31:MEM_AW+2],
                      data_sram_addr[1:0]};

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b11);
  assign w_load  = LOAD_C + CW'(r_lfsr[3:2]);
`else
  assign w_stall = 1'b0;
  assign w_load  = LOAD_C;
`endif

  // r_run holds addr_ok low until the first edge after reset release.
  // Full detection uses the MSB of the registered count (OT_DEPTH is a
  // power of two), so a full queue never accepts even while it pops.
  assign data_sram_addr_ok = r_run & ~r_count[PW] & ~w_stall;
  assign w_accept          = data_sram_req & data_sram_addr_ok;

  // Only the head may respond; a younger entry that is ready first waits.
  assign data_sram_data_ok = (r_count != '0) && (r_qCnt[r_head] == '0);
  assign w_pop             = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && !r_qWr[r_head]) ?
                             r_qData[r_head] : 32'h0;

  // Backing store: not reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          r_mem[w_idx][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Outstanding-request queue. Reads capture the word at the accept edge,
  // which already reflects any write accepted on an earlier edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_run   <= 1'b0;
      for (int i = 0; i < OT_DEPTH; i++) begin
        r_qWr[i]   <= 1'b0;
        r_qData[i] <= 32'h0;
        r_qCnt[i]  <= '0;
      end
    end else begin
      r_run <= 1'b1;
      for (int i = 0; i < OT_DEPTH; i++) begin
        if (r_qCnt[i] != '0) begin
          r_qCnt[i] <= r_qCnt[i] - CNT_ONE;
        end
      end
      if (w_accept) begin
        r_qWr[r_tail]   <= data_sram_wr;
        r_qData[r_tail] <= data_sram_wr ? 32'h0 : r_mem[w_idx];
        r_qCnt[r_tail]  <= w_load;
        r_tail          <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
